// File: rtl/memory.sv
// memory: single-port synchronous RAM with separate write and read enables.
// Depth is 2**width words of data_width bits. The whole array is cleared by a
// synchronous reset so no unknown values can ever be read back.
//
// Read handshake: a read is accepted on any rising edge where reset=0 and
// read_enb=1. On the following cycle data_out carries the word and read_valid
// is high for exactly that one cycle. There is no back-pressure. When no read
// is accepted, read_valid drops to 0 and data_out keeps its last value.
module memory #(
   parameter int width      = 4,
   parameter int data_width = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_enb,
   input  logic                  read_enb,
   input  logic [width-1:0]      address,
   input  logic [data_width-1:0] data_in,
   output logic [data_width-1:0] data_out,
   output logic                  read_valid
);

   localparam int depth = 1 << width;

   logic [data_width-1:0] mem [depth];

   // Storage array: cleared on reset, otherwise written when write_enb is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < depth; i++) begin
            mem[i] <= '0;
         end
      end else if (write_enb) begin
         mem[address] <= data_in;
      end
   end

   // Read port. Reads and writes share one address, so a read together with a
   // write always collides. The write wins, and the new data is forwarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out   <= '0;
         read_valid <= 1'b0;
      end else begin
         read_valid <= read_enb;
         if (read_enb) begin
            data_out <= write_enb ? data_in : mem[address];
         end
      end
   end

endmodule

// File: tb/tb_memory.sv
// tb_memory: self-checking bench for memory. Directed scenarios are followed
// by a randomized run. Every cycle of the random run is checked against a
// behavioural model that keeps an array of words plus the expected read
// result.
module tb_memory;

   localparam int W  = 4;
   localparam int DW = 8;
   localparam int DEPTH = 1 << W;

   logic          clk;
   logic          reset;
   logic          write_enb;
   logic          read_enb;
   logic [W-1:0]  address;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          read_valid;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] exp_data;
   logic          exp_valid;

   memory #(.width(W), .data_width(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .write_enb  (write_enb),
      .read_enb   (read_enb),
      .address    (address),
      .data_in    (data_in),
      .data_out   (data_out),
      .read_valid (read_valid)
   );

   // Clock and initial input values.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      reset     = 1'b0;
      write_enb = 1'b0;
      read_enb  = 1'b0;
      address   = '0;
      data_in   = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      exp_data  = '0;
      exp_valid = 1'b0;
   end

   // Driver task. It applies one cycle of inputs and updates the model with
   // the effect of the coming edge. It returns 1 time unit after that edge,
   // when the outputs are stable.
   task automatic step(input logic rst, input logic we, input logic re,
                       input logic [W-1:0] a, input logic [DW-1:0] d);
      reset     = rst;
      write_enb = we;
      read_enb  = re;
      address   = a;
      data_in   = d;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
         exp_data  = '0;
         exp_valid = 1'b0;
      end else begin
         if (re) begin
            exp_data  = we ? d : ref_mem[a];
            exp_valid = 1'b1;
         end else begin
            exp_valid = 1'b0;
         end
         if (we) ref_mem[a] = d;
      end
      @(posedge clk);
      #1;
      reset     = 1'b0;
      write_enb = 1'b0;
      read_enb  = 1'b0;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
      n_checks++;
      if (data_out !== 8'h00 || read_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out: data_out=%h read_valid=%b, want 00/0", data_out, read_valid);
      end
      step(1'b0, 1'b0, 1'b1, 4'h0, 8'h00);
      n_checks++;
      if (data_out !== 8'h00 || read_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_read0: data_out=%h read_valid=%b, want 00/1", data_out, read_valid);
      end
      step(1'b0, 1'b0, 1'b1, 4'hF, 8'h00);
      n_checks++;
      if (data_out !== 8'h00 || read_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_readF: data_out=%h read_valid=%b, want 00/1", data_out, read_valid);
      end
      step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
      n_checks++;
      if (read_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL valid_drop: read_valid=%b, want 0", read_valid);
      end
   endtask

   task automatic test_single_write_read();
      step(1'b0, 1'b1, 1'b0, 4'h3, 8'hA5);
      n_checks++;
      if (read_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL write_no_valid: read_valid=%b, want 0", read_valid);
      end
      step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 4'h3, 8'h00);
      n_checks++;
      if (data_out !== 8'hA5 || read_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL single_read: data_out=%h read_valid=%b, want a5/1", data_out, read_valid);
      end
   endtask

   task automatic test_multi_hold();
      step(1'b0, 1'b1, 1'b0, 4'h1, 8'h11);
      step(1'b0, 1'b1, 1'b0, 4'h2, 8'h22);
      step(1'b0, 1'b1, 1'b0, 4'h3, 8'h33);
      step(1'b0, 1'b0, 1'b1, 4'h1, 8'h00);
      n_checks++;
      if (data_out !== 8'h11 || read_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL multi_read1: data_out=%h read_valid=%b, want 11/1", data_out, read_valid);
      end
      step(1'b0, 1'b0, 1'b0, 4'h2, 8'h00);
      n_checks++;
      if (data_out !== 8'h11 || read_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold: data_out=%h read_valid=%b, want 11/0", data_out, read_valid);
      end
      step(1'b0, 1'b0, 1'b1, 4'h3, 8'h00);
      n_checks++;
      if (data_out !== 8'h33 || read_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL multi_read3: data_out=%h read_valid=%b, want 33/1", data_out, read_valid);
      end
   endtask

   task automatic test_read_after_write();
      step(1'b0, 1'b1, 1'b0, 4'h5, 8'h05);
      step(1'b0, 1'b0, 1'b1, 4'h5, 8'h00);
      n_checks++;
      if (data_out !== 8'h05 || read_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL raw: data_out=%h read_valid=%b, want 05/1", data_out, read_valid);
      end
   endtask

   task automatic test_collision();
      step(1'b0, 1'b1, 1'b0, 4'h7, 8'h10);
      step(1'b0, 1'b1, 1'b1, 4'h7, 8'h99);
      n_checks++;
      if (data_out !== 8'h99 || read_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL collide: data_out=%h read_valid=%b, want 99/1", data_out, read_valid);
      end
      step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 4'h7, 8'h00);
      n_checks++;
      if (data_out !== 8'h99) begin
         n_fail++;
         $display("FAIL collide_stored: data_out=%h, want 99", data_out);
      end
   endtask

   task automatic test_boundary();
      step(1'b0, 1'b1, 1'b0, 4'hF, 8'hC3);
      step(1'b0, 1'b1, 1'b0, 4'h0, 8'h3C);
      step(1'b0, 1'b0, 1'b1, 4'hF, 8'h00);
      n_checks++;
      if (data_out !== 8'hC3) begin
         n_fail++;
         $display("FAIL boundary_F: data_out=%h, want c3", data_out);
      end
      step(1'b0, 1'b0, 1'b1, 4'h0, 8'h00);
      n_checks++;
      if (data_out !== 8'h3C) begin
         n_fail++;
         $display("FAIL boundary_0: data_out=%h, want 3c", data_out);
      end
   endtask

   task automatic test_reset_mid();
      // Reset wins over a simultaneous write and read.
      step(1'b1, 1'b1, 1'b1, 4'h3, 8'hFF);
      n_checks++;
      if (data_out !== 8'h00 || read_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_out: data_out=%h read_valid=%b, want 00/0", data_out, read_valid);
      end
      step(1'b0, 1'b0, 1'b1, 4'h3, 8'h00);
      n_checks++;
      if (data_out !== 8'h00 || read_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_read3: data_out=%h read_valid=%b, want 00/1", data_out, read_valid);
      end
      step(1'b0, 1'b0, 1'b1, 4'h7, 8'h00);
      n_checks++;
      if (data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid_read7: data_out=%h, want 00", data_out);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), W'($urandom_range(0, DEPTH - 1)),
              DW'($urandom));
         n_checks++;
         if (data_out !== exp_data || read_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL random[%0d]: data_out=%h read_valid=%b, want %h/%b",
                     n, data_out, read_valid, exp_data, exp_valid);
         end
      end
      // Sweep every address so the contents left by the random run are checked.
      for (int a = 0; a < DEPTH; a++) begin
         step(1'b0, 1'b0, 1'b1, W'(a), 8'h00);
         n_checks++;
         if (data_out !== exp_data || read_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep[%0d]: data_out=%h read_valid=%b, want %h/1",
                     a, data_out, read_valid, exp_data);
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_single_write_read();
      test_multi_hold();
      test_read_after_write();
      test_collision();
      test_boundary();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
